// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall encodings, exception codes and sequencer states for pipe_ctrl
package pipe_ctrl_pkg;
  localparam logic [5:0] NoStall  = 6'b000000;
  localparam logic [5:0] StallId  = 6'b000111;
  localparam logic [5:0] StallEx  = 6'b001111;
  localparam logic [5:0] StallMem = 6'b011111;
  localparam logic [5:0] StallAll = 6'b111111;
  localparam logic [31:0] ExcEret = 32'h0000_000e;
  typedef enum logic [1:0] {RUN, EXC_WAIT, FLUSH} state_t;
endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// stall_watchdog: counts stalled cycles and raises a sticky flag after WDOG_LIMIT consecutive stalls
module stall_watchdog #(
  parameter int WDOG_LIMIT = 1024,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_pc,
  output logic [CNT_W-1:0] stall_cycle_cnt,
  output logic             stall_timeout
);
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [WD_W-1:0] Limit = WD_W'(WDOG_LIMIT);
  logic [WD_W-1:0] wd, wd_next;
  always_comb wd_next = !stall_pc ? '0 : wd == Limit ? Limit : wd + WD_W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wd <= '0;
      stall_cycle_cnt <= '0;
      stall_timeout <= 1'b0;
    end else begin
      wd <= wd_next;
      stall_cycle_cnt <= stall_cycle_cnt + CNT_W'(stall_pc);
      stall_timeout <= stall_timeout | (wd_next == Limit);
    end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stage stall requests and sequences exception/eret flushes with a redirect PC
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int WDOG_LIMIT = 1024,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_if,
  input  logic             stallreq_from_id,
  input  logic             stallreq_from_ex,
  input  logic             stallreq_from_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cycle_cnt,
  output logic             stall_timeout
);
  state_t state;
  logic [31:0] target, exc_target;
  logic exc;
  always_comb begin
    exc = |excepttype_i;
    exc_target = excepttype_i == ExcEret ? cp0_epc_i : EXC_VECTOR;
    stall = rst || state == FLUSH ? NoStall :
            state == EXC_WAIT || exc ? StallAll :
            stallreq_from_mem ? StallMem :
            stallreq_from_ex ? StallEx :
            stallreq_from_id || stallreq_from_if ? StallId : NoStall;
  end
  // an exception waits out any outstanding data bus access before flushing
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      flush <= 1'b0;
      new_pc <= '0;
      target <= '0;
    end else begin
      flush <= 1'b0;
      case (state)
        RUN:
          if (exc) begin
            target <= exc_target;
            state <= stallreq_from_mem ? EXC_WAIT : FLUSH;
            flush <= !stallreq_from_mem;
            if (!stallreq_from_mem) new_pc <= exc_target;
          end
        EXC_WAIT:
          if (!stallreq_from_mem) begin
            state <= FLUSH;
            flush <= 1'b1;
            new_pc <= target;
          end
        default: state <= RUN;
      endcase
    end
  stall_watchdog #(.WDOG_LIMIT(WDOG_LIMIT), .CNT_W(CNT_W)) u_wd (
    .clk(clk),
    .rst(rst),
    .stall_pc(stall[0]),
    .stall_cycle_cnt(stall_cycle_cnt),
    .stall_timeout(stall_timeout)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table vectors, directed corner sequences and random stimulus against a reference model
module tb_pipe_ctrl;
  localparam int LIM = 8;
  logic clk = 0, rst = 1;
  logic s_if = 0, s_id = 0, s_ex = 0, s_mem = 0;
  logic [31:0] exc = 0, epc = 0;
  logic [5:0] stall;
  logic flush, stall_timeout;
  logic [31:0] new_pc, cnt;
  int errors = 0, checks = 0;

  pipe_ctrl #(.EXC_VECTOR(32'h20), .WDOG_LIMIT(LIM), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .stallreq_from_if(s_if), .stallreq_from_id(s_id),
    .stallreq_from_ex(s_ex), .stallreq_from_mem(s_mem),
    .excepttype_i(exc), .cp0_epc_i(epc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_cycle_cnt(cnt), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  // reference model: pending-exception bookkeeping plus plain counters
  bit m_wait, m_flush, m_to;
  logic [31:0] m_pc, m_tgt, m_cnt;
  int m_wd;
  logic [5:0] last_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] model_stall();
    if (m_flush) return 6'd0;
    if (m_wait || exc != 0) return 6'b111111;
    if (s_mem) return 6'b011111;
    if (s_ex) return 6'b001111;
    if (s_id || s_if) return 6'b000111;
    return 6'd0;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_flush = 0; m_to = 0; m_pc = 0; m_tgt = 0; m_cnt = 0; m_wd = 0;
  endtask

  task automatic model_edge(input logic [5:0] es);
    if (es[0]) begin
      m_cnt++;
      m_wd = m_wd < LIM ? m_wd + 1 : LIM;
    end else m_wd = 0;
    if (m_wd == LIM) m_to = 1;
    if (m_flush) m_flush = 0;
    else if (m_wait) begin
      if (!s_mem) begin m_wait = 0; m_flush = 1; m_pc = m_tgt; end
    end else if (exc != 0) begin
      m_tgt = exc == 32'he ? epc : 32'h20;
      if (s_mem) m_wait = 1;
      else begin m_flush = 1; m_pc = m_tgt; end
    end
  endtask

  // entered just after a rising edge; checks comb stall mid-cycle, registered outputs after the edge
  task automatic step(input logic m, e, d, f, input logic [31:0] x, p);
    logic [5:0] es;
    s_mem = m; s_ex = e; s_id = d; s_if = f; exc = x; epc = p;
    #4;
    es = model_stall();
    chk("stall", {26'd0, stall}, {26'd0, es});
    last_stall = stall;
    @(posedge clk);
    model_edge(es);
    #1;
    chk("flush", {31'd0, flush}, {31'd0, m_flush});
    chk("new_pc", new_pc, m_pc);
    chk("stall_cycle_cnt", cnt, m_cnt);
    chk("stall_timeout", {31'd0, stall_timeout}, {31'd0, m_to});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_stall"}, {26'd0, stall}, 32'd0);
    chk({tag, "_flush"}, {31'd0, flush}, 32'd0);
    chk({tag, "_new_pc"}, new_pc, 32'd0);
    chk({tag, "_cnt"}, cnt, 32'd0);
    chk({tag, "_timeout"}, {31'd0, stall_timeout}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1; s_mem = 0; s_ex = 0; s_id = 0; s_if = 0; exc = 0; epc = 0;
    #1;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  typedef struct {
    logic m, e, d, f;
    logic [31:0] x, p;
    logic [5:0] st;
    logic fl;
    logic [31:0] pc;
  } tv_t;
  tv_t tv[9];

  initial begin
    tv[0] = '{1, 1, 1, 1, 0, 0, 6'b011111, 0, 0};
    tv[1] = '{0, 1, 1, 1, 0, 0, 6'b001111, 0, 0};
    tv[2] = '{0, 0, 1, 1, 0, 0, 6'b000111, 0, 0};
    tv[3] = '{0, 0, 0, 1, 0, 0, 6'b000111, 0, 0};
    tv[4] = '{0, 0, 0, 0, 0, 0, 6'b000000, 0, 0};
    tv[5] = '{0, 0, 0, 0, 32'h8, 0, 6'b111111, 1, 32'h20};
    tv[6] = '{0, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h20};
    tv[7] = '{0, 0, 0, 0, 32'he, 32'hBFC0_0100, 6'b111111, 1, 32'hBFC0_0100};
    tv[8] = '{0, 0, 0, 0, 0, 0, 6'b000000, 0, 32'hBFC0_0100};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(tv[i].m, tv[i].e, tv[i].d, tv[i].f, tv[i].x, tv[i].p);
      chk($sformatf("tv%0d_stall", i), {26'd0, last_stall}, {26'd0, tv[i].st});
      chk($sformatf("tv%0d_flush", i), {31'd0, flush}, {31'd0, tv[i].fl});
      chk($sformatf("tv%0d_new_pc", i), new_pc, tv[i].pc);
    end

    // deferred flush: exception while mem busy, later exceptions ignored
    step(1, 0, 0, 0, 32'hc, 0);
    chk("defer_stall0", {26'd0, last_stall}, 32'h3f);
    chk("defer_noflush0", {31'd0, flush}, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, i == 1 ? 32'he : 0, 32'h1234);
      chk("defer_stall", {26'd0, last_stall}, 32'h3f);
      chk("defer_noflush", {31'd0, flush}, 0);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("defer_stall_last", {26'd0, last_stall}, 32'h3f);
    chk("defer_flush", {31'd0, flush}, 1);
    chk("defer_new_pc", new_pc, 32'h20);
    step(0, 0, 0, 0, 32'h8, 0);
    chk("flush_cycle_stall", {26'd0, last_stall}, 0);
    chk("flush_drop", {31'd0, flush}, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("post_flush", {31'd0, flush}, 0);

    // random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] x;
      int r;
      r = $urandom_range(0, 19);
      x = r == 0 ? 32'h8 : r == 1 ? 32'he : r == 2 ? 32'hc : 32'h0;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, x, $urandom);
    end

    // watchdog
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 0, 0, 0, 0);
      if (i == 7) chk("wdog_before", {31'd0, stall_timeout}, 0);
      if (i == 8) chk("wdog_rise", {31'd0, stall_timeout}, 1);
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("wdog_sticky", {31'd0, stall_timeout}, 1);
    chk("wdog_cnt", cnt, 10);

    // async reset during EXC_WAIT
    do_reset();
    step(1, 0, 0, 0, 32'hc, 0);
    step(1, 0, 0, 0, 0, 0);
    rst = 1;
    #1;
    chk("rst_wait_stall", {26'd0, stall}, 0);
    chk("rst_wait_flush", {31'd0, flush}, 0);
    chk("rst_wait_cnt", cnt, 0);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("rst_wait_noflush", {31'd0, flush}, 0);
    end

    // async reset during FLUSH
    step(0, 0, 0, 0, 32'h8, 0);
    chk("pre_rst_flush", {31'd0, flush}, 1);
    rst = 1;
    #1;
    chk("rst_flush_flush", {31'd0, flush}, 0);
    chk("rst_flush_pc", new_pc, 0);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    step(0, 0, 0, 0, 0, 0);
    chk("rst_flush_after", {31'd0, flush}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
